// File: rtl/dtlb_ptw.sv
// Two-level page-table walker that refills a DTLB on a miss.
// Optional one-entry L1 PTE cache enabled by macro DTLB_PTW_L1CACHE_EN.
module dtlb_ptw #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_miss,
   input  logic [19:0] i_miss_vpn,
   input  logic [7:0]  i_ptbr,
   input  logic        i_flush,
   output logic        o_busy,
   output logic        o_mem_req,
   output logic [19:0] o_mem_addr,
   input  logic        i_mem_ready,
   input  logic [31:0] i_mem_rdata,
   output logic        o_write_en,
   output logic [19:0] o_write_vpn,
   output logic [7:0]  o_write_ppn,
   output logic        o_fault
);

   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] LastWait = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [2:0] {StIdle, StL1Req, StL2Req, StRefill, StFault} state_e;

   state_e          r_state, w_state_nxt;
   logic [19:0]     r_vpn, w_vpn_nxt;
   logic [7:0]      r_ptbr, w_ptbr_nxt;
   logic [7:0]      r_l1_ppn, w_l1_ppn_nxt;
   logic [7:0]      r_l2_ppn, w_l2_ppn_nxt;
   logic [CntW-1:0] r_wait, w_wait_nxt;
   logic            w_timeout;
   logic            w_hit;
   logic [7:0]      w_hit_ppn;
   logic            w_unused_rdata;

   assign w_unused_rdata = ^i_mem_rdata[30:8];
   assign w_timeout = (TIMEOUT != 0) && (r_wait == LastWait);

`ifdef DTLB_PTW_L1CACHE_EN
   logic       r_c_valid;
   logic [7:0] r_c_ptbr;
   logic [9:0] r_c_vpn;
   logic [7:0] r_c_ppn;

   assign w_hit     = r_c_valid && (r_c_ptbr == i_ptbr) && (r_c_vpn == i_miss_vpn[19:10]);
   assign w_hit_ppn = r_c_ppn;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_c_valid <= 1'b0;
         r_c_ptbr  <= '0;
         r_c_vpn   <= '0;
         r_c_ppn   <= '0;
      end else if (i_flush || (w_state_nxt == StFault && r_state != StFault)) begin
         r_c_valid <= 1'b0;
      end else if (r_state == StL1Req && i_mem_ready && i_mem_rdata[31]) begin
         r_c_valid <= 1'b1;
         r_c_ptbr  <= r_ptbr;
         r_c_vpn   <= r_vpn[19:10];
         r_c_ppn   <= i_mem_rdata[7:0];
      end
   end
`else
   assign w_hit     = 1'b0;
   assign w_hit_ppn = 8'h00;
`endif

   always_comb begin
      w_state_nxt  = r_state;
      w_vpn_nxt    = r_vpn;
      w_ptbr_nxt   = r_ptbr;
      w_l1_ppn_nxt = r_l1_ppn;
      w_l2_ppn_nxt = r_l2_ppn;
      if (i_flush) begin
         w_state_nxt = StIdle;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (i_miss) begin
                  w_vpn_nxt  = i_miss_vpn;
                  w_ptbr_nxt = i_ptbr;
                  if (w_hit) begin
                     w_l1_ppn_nxt = w_hit_ppn;
                     w_state_nxt  = StL2Req;
                  end else begin
                     w_state_nxt = StL1Req;
                  end
               end
            end
            StL1Req: begin
               if (i_mem_ready) begin
                  w_state_nxt  = i_mem_rdata[31] ? StL2Req : StFault;
                  w_l1_ppn_nxt = i_mem_rdata[7:0];
               end else if (w_timeout) begin
                  w_state_nxt = StFault;
               end
            end
            StL2Req: begin
               if (i_mem_ready) begin
                  w_state_nxt  = i_mem_rdata[31] ? StRefill : StFault;
                  w_l2_ppn_nxt = i_mem_rdata[7:0];
               end else if (w_timeout) begin
                  w_state_nxt = StFault;
               end
            end
            default: w_state_nxt = StIdle;
         endcase
      end
      // Any state change restarts the per-request wait count.
      w_wait_nxt = (w_state_nxt != r_state) ? '0 : r_wait + 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= StIdle;
         r_vpn    <= '0;
         r_ptbr   <= '0;
         r_l1_ppn <= '0;
         r_l2_ppn <= '0;
         r_wait   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_vpn    <= w_vpn_nxt;
         r_ptbr   <= w_ptbr_nxt;
         r_l1_ppn <= w_l1_ppn_nxt;
         r_l2_ppn <= w_l2_ppn_nxt;
         r_wait   <= w_wait_nxt;
      end
   end

   always_comb begin
      o_busy      = (r_state != StIdle);
      o_mem_req   = (r_state == StL1Req || r_state == StL2Req) && !i_flush;
      o_mem_addr  = '0;
      if (o_mem_req) begin
         o_mem_addr = (r_state == StL1Req) ? {r_ptbr, r_vpn[19:10], 2'b00}
                                           : {r_l1_ppn, r_vpn[9:0], 2'b00};
      end
      o_write_en  = (r_state == StRefill) && !i_flush;
      o_write_vpn = o_write_en ? r_vpn : '0;
      o_write_ppn = o_write_en ? r_l2_ppn : '0;
      o_fault     = (r_state == StFault) && !i_flush;
   end

endmodule

// File: doc/dtlb_ptw.md
DTLB_PTW -- requirements
Module: dtlb_ptw

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 64, giving the maximum cycles a memory request waits for mem_ready before faulting; a value of 0 SHALL disable the timeout.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port miss, input, 1 bit: DTLB translation miss; held by the DTLB until refill or fault.
REQ-005 The block SHALL have port miss_vpn, input, 20 bits (vpn_t): the VPN that missed.
REQ-006 The block SHALL have port ptbr, input, 8 bits (ppn_t): the PPN of the level-1 page table.
REQ-007 The block SHALL have port flush, input, 1 bit: abort any walk and drop cached state.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 The block SHALL have port mem_req, output, 1 bit: memory read request.
REQ-010 The block SHALL have port mem_addr, output, 20 bits: byte address of the PTE being read.
REQ-011 The block SHALL have port mem_ready, input, 1 bit: read data valid; meaningful only while mem_req=1.
REQ-012 The block SHALL have port mem_rdata, input, 32 bits: PTE; bit 31 = valid, bits 7:0 = PPN.
REQ-013 The block SHALL have ports write_en (1), write_vpn (20) and write_ppn (8), outputs, forming the DTLB refill; write_en pulses for one cycle.
REQ-014 The block SHALL have port fault, output, 1 bit: one-cycle pulse on an invalid PTE or a timeout.

Function
REQ-015 The FSM SHALL have states IDLE, L1_REQ, L2_REQ, REFILL and FAULT.
REQ-016 In IDLE with miss=1 and flush=0, the block SHALL latch miss_vpn and ptbr and enter L1_REQ on the next edge.
REQ-017 In L1_REQ, the block SHALL drive mem_req=1 and mem_addr={ptbr_latched, vpn[19:10], 2'b00}.
REQ-018 In L2_REQ, the block SHALL drive mem_req=1 and mem_addr={l1_pte[7:0], vpn[9:0], 2'b00}.
REQ-019 mem_req and mem_addr SHALL stay stable until the cycle mem_ready=1; the handshake completes in that cycle.
REQ-020 On L1 completion, rdata[31]=1 SHALL go to L2_REQ (storing rdata[7:0]); rdata[31]=0 SHALL go to FAULT.
REQ-021 On L2 completion, rdata[31]=1 SHALL go to REFILL (storing rdata[7:0]); rdata[31]=0 SHALL go to FAULT.
REQ-022 In REFILL, the block SHALL assert write_en=1 with write_vpn=latched VPN and write_ppn=L2 PPN for exactly one cycle, then return to IDLE.
REQ-023 In FAULT, the block SHALL assert fault=1 for exactly one cycle, then return to IDLE.
REQ-024 Minimum miss-to-write_en latency with zero-wait memory SHALL be 3 cycles.
REQ-025 A per-request wait counter SHALL clear on entering L1_REQ or L2_REQ; when TIMEOUT>0 and the counter reaches TIMEOUT without mem_ready, the block SHALL go to FAULT.
REQ-026 flush=1 in any state SHALL force IDLE on the next edge with mem_req=0, and any write_en or fault for that cycle SHALL be suppressed.
REQ-027 flush SHALL take priority over miss, mem_ready and timeout when they occur in the same cycle.
REQ-028 miss SHALL be ignored in any state other than IDLE.
REQ-029 A miss present in the REFILL or FAULT cycle SHALL be sampled only once the block is back in IDLE.
REQ-030 After a walk, in the IDLE cycle the DTLB's miss is expected to drop; if miss remains high there, a new walk SHALL start.

Reset
REQ-031 While rst=1, the block SHALL be in IDLE, with busy, mem_req, write_en and fault at 0, mem_addr, write_vpn and write_ppn at 0, the wait counter cleared, and the L1 cache invalid.
REQ-032 Reset asserted mid-walk SHALL abandon the walk immediately, asynchronously, with no write_en or fault.

Configuration
REQ-033 With macro DTLB_PTW_L1CACHE_EN defined, the block SHALL keep a one-entry cache {valid, ptbr, vpn[19:10], l1 ppn}, filled on every valid L1 PTE.
REQ-034 With DTLB_PTW_L1CACHE_EN defined, a miss in IDLE whose ptbr and vpn[19:10] match a valid cache entry SHALL skip L1_REQ and enter L2_REQ directly, giving a 2-cycle minimum latency.
REQ-035 With DTLB_PTW_L1CACHE_EN defined, the cache SHALL be invalidated by flush, by reset and by entering FAULT.
REQ-036 Without DTLB_PTW_L1CACHE_EN, no cache storage SHALL exist and every walk SHALL perform two memory reads.

Verification
REQ-037 Basic walk: ptbr=8'h10, miss_vpn=20'h00403, zero-wait memory, L1 PTE 32'h80000022, L2 PTE 32'h80000055 -> mem_addr 20'h10004 then 20'h2200C, write_en one cycle with vpn 20'h00403 and ppn 8'h55.
REQ-038 Invalid L2 PTE: same setup with L2 rdata=32'h00000055 -> fault one cycle, no write_en, then IDLE.
REQ-039 Timeout: TIMEOUT=4, mem_ready held 0 -> fault in the cycle after the 4th wait cycle, and mem_req drops.
REQ-040 Flush during L2_REQ, with flush and mem_ready both 1 in the same cycle -> IDLE next cycle, no write_en, no fault.
REQ-041 Back-to-back: second miss vpn=20'h00404 after the first refill -> with DTLB_PTW_L1CACHE_EN, a single mem access at 20'h22010; without it, two accesses.
REQ-042 Async reset asserted during L1_REQ with mem_req=1 -> mem_req=0 and busy=0 before the next clock edge.
